// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path definitions: architectural widths, the default reset PC
// and the {pc, instr} entry carried from the fetch FIFO to decode.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch is word-granular; the low two PC bits are always dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched {pc, instr} entries with a flush that
// discards everything; the producer guarantees it never pushes into a full FIFO.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all of them sample pre-edge values.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one-word requests to a
// one-cycle-latency memory, buffers responses and hands them to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [AW:0]     fifo_count;
  logic [AW:0]     occupancy;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop, accept, push;

  // Credit check: entries held plus the one in flight, less the one leaving now,
  // must leave room for the response of any request issued this cycle.
  always_comb begin
    instr_valid = !rst && (fifo_count != '0);
    pop         = instr_valid && instr_ready;
    occupancy   = fifo_count + {{AW{1'b0}}, inflight_q} - {{AW{1'b0}}, pop};
    imem_req    = !rst && !redirect && (occupancy < DEPTH_C);
    accept      = imem_req && imem_ready;
    push        = imem_rvalid && inflight_q && !redirect;
    push_entry  = '{pc: inflight_pc_q, instr: imem_rdata};
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d       = align_pc(redirect_pc);
      inflight_d = 1'b0;
    end else if (accept) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else if (imem_rvalid && inflight_q) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= align_pc(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A redirect flushes the FIFO, so a pop in the same cycle must not move the pointers.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop && !redirect),
    .head       (head),
    .count      (fifo_count)
  );

  assign imem_addr = pc_q;
  assign instr     = instr_valid ? head.instr : '0;
  assign instr_pc  = instr_valid ? head.pc    : '0;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end sitting directly upstream of the decode stage. It owns the program counter, issues word-aligned requests to a fixed-latency instruction memory, buffers returned words with their PCs in a small FIFO, and presents them to decode through a valid/ready handshake. A redirect input from the branch/jump path flushes everything in flight and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid, exactly one cycle after an accepted request
- imem_rdata  in  32  returned instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- instr_valid  out  1  FIFO head valid to decode
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction word
- instr_pc  out  32  PC of head instruction

## Operation
- State: pc (32), FIFO of {pc, instr} entries with count, inflight flag (1 accepted request awaiting response), inflight_pc.
- Request issue: imem_req = !rst && !redirect && (count + inflight − pop) < DEPTH, where pop = instr_valid && instr_ready. imem_addr = pc.
- Accept = imem_req && imem_ready: pc ← pc + 4 (wraps modulo 2^32), inflight ← 1, inflight_pc ← pc. No accept: pc holds, address held stable while imem_req stays high.
- Response: imem_rvalid with inflight set and no redirect pushes {inflight_pc, imem_rdata}; inflight clears unless a new accept occurs in the same cycle.
- Credit rule guarantees a push never finds the FIFO full; push and pop in the same cycle are both performed, count unchanged.
- instr_valid = (count != 0); instr/instr_pc = head entry, 0 when empty.
- Redirect (cycle t): FIFO cleared, inflight cleared, any imem_rvalid in cycle t discarded, imem_req forced 0, pc ← {redirect_pc[31:2], 2'b00}. Pop in cycle t has no effect. Redirect has priority over all other events.
- imem_rvalid without inflight set: ignored (protocol error, no state change).

## Timing
- Reset: pc = RESET_PC, count = 0, inflight = 0; during rst: imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0. First request in the first cycle rst is low.
- Request accepted cycle c → response c+1 → instr_valid at c+2 (FIFO registered, no bypass).
- Steady state with imem_ready = instr_ready = 1: one instruction per cycle to decode after initial 2-cycle fill.
- Redirect at t: first request for redirect_pc at t+1, its instr_valid at t+3.
- Decode stall: with DEPTH = 2, at most 2 entries buffered; requests stop until pops free credit, resume the cycle a pop occurs.
- rst asserted mid-operation: all state returns to reset values at that edge; responses arriving during or the cycle after rst are discarded (inflight = 0).

## Structure
- Shared core package: XLEN = 32, ILEN = 32, default RESET_PC constant, fetch entry struct {pc, instr}.
- One sub-module: fetch_fifo (parameterised DEPTH, push/pop/flush, count output, synchronous active-high reset); fetch_stage holds pc, inflight tracking and credit logic.

## Test plan
- Reset release, imem_ready = instr_ready = 1, rdata = addr ^ 32'hFFFF_FFFF → addresses 0,4,8,…; first instr_valid 2 cycles after first request; instr_pc matches address, one per cycle.
- instr_ready = 0 for 10 cycles → exactly 2 entries buffered, imem_req low after fill; release → entries delivered in order at PCs 0,4 then 8, no loss or duplication.
- imem_ready toggling 1/0 → imem_addr stable while not accepted, pc advances only on accepts, output stream gap-free in PC.
- Redirect to 32'h0000_1003 with 2 buffered + 1 inflight → FIFO empties next cycle, stale response dropped, imem_req low at t, address 32'h0000_1000 at t+1, instr_valid at t+3.
- pc = 32'hFFFF_FFFC → next request address 32'h0000_0000.
- rst asserted with full FIFO and inflight request → instr_valid 0 next cycle, response in following cycle ignored, fetch restarts at RESET_PC.
